// File: rtl/res_uart_tx_pkg.sv
// Shared types and constants for the result-byte UART transmitter.
// Frame layout constants and the transmitter FSM state encoding live here.
package res_uart_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Integer clock cycles per serial bit; callers guarantee the result is >= 2.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/res_uart_tx_if.sv
// Result-stream and serial-line bundle between the FIB result source and the UART stage.
// Handshake: code_valid is a one-cycle strobe with no ready; a byte is accepted at an edge
// where code_valid=1 and fifo_full=0, otherwise it is dropped and the sticky overflow flag is set.
interface res_uart_tx_if;
    import res_uart_tx_pkg::*;

    logic [7:0]  code_in;
    logic        code_valid;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    uart_state_t state;

    modport master (
        output code_in,
        output code_valid,
        input  tx,
        input  busy,
        input  fifo_full,
        input  overflow,
        input  state
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output tx,
        output busy,
        output fifo_full,
        output overflow,
        output state
    );

endinterface

// File: rtl/res_uart_tx_fifo.sv
// Synchronous FIFO with flop storage; head is read straight from the storage flops.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: empty is decided by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/res_uart_tx.sv
// Buffers FIB result bytes and serialises them as UART 8N1, LSB first, on one line.
// Holds the baud counter, bit index, shift register, FSM and sticky overflow flag.
module res_uart_tx
    import res_uart_tx_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200,
    parameter int DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    res_uart_tx_if.slave  bus
);

    localparam int            CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int            CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST     = 3'(DATA_BITS - 1);

    uart_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_r;
    logic          busy_r;
    logic          overflow_r;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          bit_done;

    assign bit_done = (baud_cnt == CNT_LAST);
    // full is a registered view, so a strobe while full is dropped even if a pop happens the same edge.
    assign push     = bus.code_valid && !fifo_full;
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

    res_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (bus.code_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift  <= fifo_dout;
                        tx_r   <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        tx_r     <= shift[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            tx_r  <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Bit 0 of shift is the bit on the line; expose the next one.
                            shift   <= shift >> 1;
                            tx_r    <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_dout;
                            tx_r  <= 1'b0;
                            state <= START;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (bus.code_valid && fifo_full) begin
            overflow_r <= 1'b1;
        end
    end

    assign bus.tx        = tx_r;
    assign bus.busy      = busy_r;
    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = overflow_r;
    assign bus.state     = state;

endmodule
